pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage MIPS core. Merges per-stage stall

---
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests into the stall vector and
// sequences exception/ERET redirects (drain in-flight fetch, then a one-cycle flush).
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_TYPE  = 32'h0000000E,
    parameter int          WDOG_CYC   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        if_busy_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles_o,
    output logic        wdog_o,
    output logic [1:0]  o_dbg_state
);

    localparam int WW = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYC);
    localparam logic [WW-1:0] WDOG_PRE = WW'(WDOG_CYC - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_type;
    logic [31:0]   r_epc;
    logic          r_flush;
    logic [31:0]   r_new_pc;
    logic [31:0]   r_stall_cycles;
    logic [WW-1:0] r_wdog_cnt;
    logic          r_wdog;

    logic          w_exc;
    logic [5:0]    w_stall;

    assign w_exc = (excepttype_i != 32'd0);

    // A pending exception freezes the whole pipe so the excepting instruction cannot retire twice.
    always_comb begin
        w_stall = 6'b000000;
        case (r_state)
            S_FLUSH: w_stall = 6'b000000;
            S_DRAIN: w_stall = 6'b111111;
            default: begin
                if (w_exc)             w_stall = 6'b111111;
                else if (stallreq_mem) w_stall = 6'b011111;
                else if (stallreq_ex)  w_stall = 6'b001111;
                else if (stallreq_id)  w_stall = 6'b000111;
                else if (stallreq_if)  w_stall = 6'b000011;
                else                   w_stall = 6'b000000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_type   <= 32'd0;
            r_epc    <= 32'd0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_exc) begin
                        r_type <= excepttype_i;
                        r_epc  <= cp0_epc_i;
                        if (if_busy_i) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state  <= S_FLUSH;
                            r_flush  <= 1'b1;
                            r_new_pc <= (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!if_busy_i) begin
                        r_state  <= S_FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= (r_type == ERET_TYPE) ? r_epc : EXC_VECTOR;
                    end
                end
                S_FLUSH: begin
                    r_state  <= S_RUN;
                    r_flush  <= 1'b0;
                    r_new_pc <= 32'd0;
                end
                default: begin
                    r_state  <= S_RUN;
                    r_flush  <= 1'b0;
                    r_new_pc <= 32'd0;
                end
            endcase
        end
    end

    // Watchdog count saturates; the sticky flag rises on the same edge the count reaches the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
            r_wdog_cnt     <= '0;
            r_wdog         <= 1'b0;
        end else begin
            if (w_stall[1]) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_stall != 6'b000000) begin
                if (r_wdog_cnt != WDOG_MAX) r_wdog_cnt <= r_wdog_cnt + 1'b1;
                if (r_wdog_cnt == WDOG_PRE) r_wdog <= 1'b1;
            end else begin
                r_wdog_cnt <= '0;
            end
        end
    end

    assign stall          = w_stall;
    assign flush          = r_flush;
    assign new_pc         = r_new_pc;
    assign stall_cycles_o = r_stall_cycles;
    assign wdog_o         = r_wdog;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, each cycle compared against
// a behavioural model of stall merging, redirect sequencing, perf counter and watchdog.
module tb_pipe_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC00380;
    localparam logic [31:0] ERET = 32'h0000000E;
    localparam int          WDOG = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sreq_if = 1'b0, sreq_id = 1'b0, sreq_ex = 1'b0, sreq_mem = 1'b0;
    logic [31:0] etype = 32'd0;
    logic [31:0] epc = 32'd0;
    logic        busy = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        wdog;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (sreq_if),
        .stallreq_id    (sreq_id),
        .stallreq_ex    (sreq_ex),
        .stallreq_mem   (sreq_mem),
        .excepttype_i   (etype),
        .cp0_epc_i      (epc),
        .if_busy_i      (busy),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .stall_cycles_o (stall_cycles),
        .wdog_o         (wdog),
        .o_dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: pending exception waiting for the fetch to drain, flush due next cycle.
    bit          m_pending;
    bit          m_flush_due;
    logic [31:0] m_pc;
    logic [31:0] m_lat_type;
    logic [31:0] m_lat_epc;
    logic [31:0] m_cycles;
    int          m_wcnt;
    bit          m_wdog;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_stall();
        int ones;
        if (m_flush_due) return 6'd0;
        if (m_pending || (etype != 32'd0)) return 6'h3F;
        ones = sreq_mem ? 5 : sreq_ex ? 4 : sreq_id ? 3 : sreq_if ? 2 : 0;
        return 6'((1 << ones) - 1);
    endfunction

    task automatic model_reset();
        m_pending = 0; m_flush_due = 0; m_pc = 0; m_lat_type = 0; m_lat_epc = 0;
        m_cycles = 0; m_wcnt = 0; m_wdog = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [5:0] es);
        if (es[1]) m_cycles = m_cycles + 32'd1;
        if (es != 6'd0) m_wcnt = (m_wcnt < WDOG) ? m_wcnt + 1 : WDOG;
        else m_wcnt = 0;
        if (m_wcnt == WDOG) m_wdog = 1;
        if (m_flush_due) begin
            m_flush_due = 0;
        end else if (m_pending) begin
            if (!busy) begin
                m_pending = 0;
                m_flush_due = 1;
                m_pc = (m_lat_type == ERET) ? m_lat_epc : VEC;
                exp_q.push_back(m_pc);
            end
        end else if (etype != 32'd0) begin
            m_lat_type = etype;
            m_lat_epc  = epc;
            if (busy) begin
                m_pending = 1;
            end else begin
                m_flush_due = 1;
                m_pc = (etype == ERET) ? epc : VEC;
                exp_q.push_back(m_pc);
            end
        end
    endtask

    // Called at posedge+1: apply inputs, check at negedge, advance model, return at next posedge+1.
    task automatic drive(input logic a_if, input logic a_id, input logic a_ex, input logic a_mem,
                         input logic [31:0] a_type, input logic [31:0] a_epc, input logic a_busy);
        logic [5:0] es;
        sreq_if = a_if; sreq_id = a_id; sreq_ex = a_ex; sreq_mem = a_mem;
        etype = a_type; epc = a_epc; busy = a_busy;
        @(negedge clk);
        es = exp_stall();
        chk("stall", {26'd0, stall}, {26'd0, es});
        chk("flush", {31'd0, flush}, {31'd0, m_flush_due});
        chk("new_pc", new_pc, m_flush_due ? m_pc : 32'd0);
        chk("stall_cycles", stall_cycles, m_cycles);
        chk("wdog", {31'd0, wdog}, {31'd0, m_wdog});
        if (flush === 1'b1) begin
            if (exp_q.size() == 0) chk("flush_unexpected", 32'd1, 32'd0);
            else chk("flush_pc_sb", new_pc, exp_q.pop_front());
        end
        model_step(es);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sreq_if = 0; sreq_id = 0; sreq_ex = 0; sreq_mem = 0;
        etype = 32'd0; epc = 32'd0; busy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_stall", {26'd0, stall}, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_new_pc", new_pc, 32'd0);
        chk("reset_cycles", stall_cycles, 32'd0);
        chk("reset_wdog", {31'd0, wdog}, 32'd0);
        do_reset();

        // Single requests, then all four together.
        drive(1, 0, 0, 0, 32'd0, 32'd0, 0);
        drive(0, 1, 0, 0, 32'd0, 32'd0, 0);
        drive(0, 0, 1, 0, 32'd0, 32'd0, 0);
        drive(0, 0, 0, 1, 32'd0, 32'd0, 0);
        drive(1, 1, 1, 1, 32'd0, 32'd0, 0);
        idle(2);

        // Plain exception, fetch idle: flush on the next cycle to the fixed vector.
        drive(0, 0, 0, 0, 32'h4, 32'h0, 0);
        chk("t2_flush", {31'd0, flush}, 32'd1);
        chk("t2_new_pc", new_pc, VEC);
        chk("t2_stall", {26'd0, stall}, 32'd0);
        idle(2);

        // ERET while a fetch is in flight for three cycles.
        drive(0, 0, 0, 0, ERET, 32'h80001234, 1);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 1);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 1);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 0);
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_new_pc", new_pc, 32'h80001234);
        idle(1);
        chk("t3_flush_once", {31'd0, flush}, 32'd0);
        idle(1);

        // Exception beats a MEM stall; stale type held through the flush cycle.
        drive(0, 0, 0, 1, 32'h8, 32'h0, 0);
        drive(0, 0, 0, 0, 32'h8, 32'h0, 0);
        idle(3);

        // Watchdog and perf counter over exactly WDOG stalled cycles.
        do_reset();
        for (int i = 0; i < WDOG - 1; i++) drive(0, 0, 1, 0, 32'd0, 32'd0, 0);
        chk("t5_wdog_early", {31'd0, wdog}, 32'd0);
        drive(0, 0, 1, 0, 32'd0, 32'd0, 0);
        chk("t5_wdog_set", {31'd0, wdog}, 32'd1);
        chk("t5_cycles", stall_cycles, 32'd1024);
        idle(3);
        chk("t5_wdog_sticky", {31'd0, wdog}, 32'd1);

        // Asynchronous reset in the middle of a drain.
        drive(0, 0, 0, 0, 32'h8, 32'h0, 1);
        drive(0, 0, 0, 0, 32'd0, 32'd0, 1);
        #2;
        chk("t6_drain_stall", {26'd0, stall}, 32'h3F);
        rst = 1'b0;
        #1;
        chk("t6_rst_flush", {31'd0, flush}, 32'd0);
        chk("t6_rst_stall", {26'd0, stall}, 32'd0);
        chk("t6_rst_cycles", stall_cycles, 32'd0);
        chk("t6_rst_wdog", {31'd0, wdog}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            logic [31:0] e;
            t = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: t = 32'h4;
                    1: t = ERET;
                    default: t = $urandom;
                endcase
            end
            e = $urandom;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  t, e, $urandom_range(0, 2) == 0);
        end
        idle(8);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
